reg_access_arbiter: RTL and testbench
=====================================

Name: reg_access_arbiter

Overview:
- Shares the single register-access master (write_start/read_start, reg_out_addr/reg_out_data, reg_in_data, master done strobes) among NUM_REQ requesters, e.g. XDMA/PCIe config init, NVMe admin init, doorbell writer.
- Round-robin, one transaction outstanding at a time.
- Each requester gets a one-cycle done pulse with captured read data.
- Sits between the init/command sequencers and the AXI-lite-style sys read/write masters.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 32'd250_000_000, watchdog limit in WAIT (used only with the optional feature).

Ports:
- aclk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- req  in  NUM_REQ  request per requester, held high until its req_done
- req_wr  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  64*NUM_REQ  flattened; slice i = [64*i+63:64*i]
- req_wdata  in  32*NUM_REQ  flattened write data
- grant  out  NUM_REQ  one-hot owner of the master
- req_done  out  NUM_REQ  one-cycle completion pulse
- req_err  out  1  valid with req_done; 1 = timed out
- req_rdata  out  32  read data, valid with req_done
- write_start  out  1  to sys write master
- read_start  out  1  to sys read master
- write_start_ack  in  1
- read_start_ack  in  1
- sys_write_master_done  in  1
- sys_read_master_done  in  1
- reg_out_addr  out  64  master address
- reg_out_data  out  32  master write data
- reg_in_data  in  32  master read data, valid on sys_read_master_done

Behaviour:
- Reset values (rst_n=0 at posedge aclk): state IDLE, grant=0, req_done=0, req_err=0, req_rdata=0, write_start=0, read_start=0, reg_out_addr=0, reg_out_data=0, last-grant pointer=NUM_REQ-1 (requester 0 has first priority).
- Reset mid-transaction abandons the master op; no done is reported.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, pick the first set bit searching from last+1 upward, wrapping modulo NUM_REQ.
  - Next cycle: grant one-hot, reg_out_addr/reg_out_data registered from the winner's slices, write_start (req_wr=1) or read_start (req_wr=0) = 1, state ISSUE.
  - Latency is one cycle from req high to start.
- ISSUE:
  - Start stays high until the matching ack (write_start_ack for writes, read_start_ack for reads); deassert on the cycle after the ack, then go to WAIT.
  - If the matching done arrives in the same cycle as the ack, go directly to RESP.
- WAIT: on the matching done (sys_write_master_done for writes, sys_read_master_done for reads), go to RESP.
- Done capture: on a read's done cycle, req_rdata <= reg_in_data. On a write, req_rdata <= 0.
- Ignored strobes: the non-matching done/ack, and any done/ack seen in IDLE, are ignored.
- RESP (one cycle):
  - req_done[owner]=1, req_err per watchdog, last <= owner, grant <= 0, next state IDLE.
  - Arbitration for the next transaction happens in IDLE, so back-to-back transactions take at least 1 idle cycle.
- Stability: grant, reg_out_addr and reg_out_data are held constant from ISSUE entry through RESP.
- Requester rules:
  - Requester inputs are sampled only at the IDLE grant decision.
  - Deasserting req while granted does not cancel the transaction.
  - A requester must drop req in the cycle after req_done, or it re-enters arbitration (allowed; it gets the lowest priority).
- Fairness: any continuously requesting requester is served within NUM_REQ transactions.

Optional Feature:
- Macro: REG_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit counter clears on entry to ISSUE and increments in ISSUE/WAIT.
  - On reaching TIMEOUT_CYCLES-1: deassert start, go to RESP with req_err=1 and req_rdata=32'hDEAD_BEEF.
  - Late done/ack strobes for the abandoned transaction that arrive in IDLE are ignored.
- When undefined: no counter, the FSM waits indefinitely, and req_err is tied 0.

Test Plan:
- Single write: req[0]=1, wr=1, addr=64'h4_0000_0004, wdata=32'h1234_5678; ack at +3, done at +10 -> write_start high cycles 1..3, reg_out_addr/data as given, req_done[0] pulses once, req_err=0, req_rdata=0.
- Single read: req[2]=1, wr=0, addr=64'ha000_001c; done with reg_in_data=32'h0001_0000 -> read_start only, req_done[2] pulse, req_rdata=32'h0001_0000.
- Contention: req=3'b111 held continuously for 6 transactions -> grant order 0,1,2,0,1,2; no overlap; each grant asserted only between start and RESP.
- Ack+done same cycle: ack and done both asserted on cycle 2 of ISSUE -> RESP next cycle; exactly one req_done; no WAIT state visited.
- Reset mid-WAIT: rst_n=0 for 1 cycle during WAIT -> all outputs 0; a subsequent stray done is ignored; next req from requester 0 is served normally.
- With REG_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100 and no done -> req_done at cycle ~101 after ISSUE entry with req_err=1, req_rdata=32'hDEAD_BEEF; the next requester is then served.

Source files
------------

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one register-access master among NUM_REQ requesters.
// Optional watchdog in ISSUE/WAIT enabled by defining REG_ARB_TIMEOUT_EN.
module reg_access_arbiter #(
    parameter int unsigned NUM_REQ        = 3,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
    input  logic                  aclk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_wr,
    input  logic [64*NUM_REQ-1:0] req_addr,
    input  logic [32*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  req_err,
    output logic [31:0]           req_rdata,
    output logic                  write_start,
    output logic                  read_start,
    input  logic                  write_start_ack,
    input  logic                  read_start_ack,
    input  logic                  sys_write_master_done,
    input  logic                  sys_read_master_done,
    output logic [63:0]           reg_out_addr,
    output logic [31:0]           reg_out_data,
    input  logic [31:0]           reg_in_data
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] own_q;
    logic             wr_q;
    logic [IDX_W-1:0] win_d;
    logic             ack_m;
    logic             done_m;
    logic             tmo_hit;

    logic [63:0] addr_arr  [NUM_REQ];
    logic [31:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[64*i +: 64];
        assign wdata_arr[i] = req_wdata[32*i +: 32];
    end

    // First requester above the last owner, wrapping; only meaningful when |r.
    function automatic logic [IDX_W-1:0] next_winner(input logic [NUM_REQ-1:0] r,
                                                      input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] w;
        logic [IDX_W-1:0] sel;
        logic             found;
        int               idx;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            idx = (int'(last) + k) % int'(NUM_REQ);
            sel = IDX_W'(idx);
            if (!found && r[sel]) begin
                found = 1'b1;
                w     = sel;
            end
        end
        return w;
    endfunction

    function automatic logic [31:0] resp_data(input logic wr, input logic [31:0] d);
        return wr ? 32'h0 : d;
    endfunction

    assign win_d  = next_winner(req, last_q);
    assign ack_m  = wr_q ? write_start_ack       : read_start_ack;
    assign done_m = wr_q ? sys_write_master_done : sys_read_master_done;

`ifdef REG_ARB_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        err_q;
    // >= so an ack landing on the limit cycle cannot strand the FSM in WAIT.
    assign tmo_hit = (tmo_q >= TIMEOUT_CYCLES - 32'd1);
    assign req_err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
    assign req_err    = 1'b0;
`endif

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant        <= '0;
            req_done     <= '0;
            req_rdata    <= '0;
            write_start  <= 1'b0;
            read_start   <= 1'b0;
            reg_out_addr <= '0;
            reg_out_data <= '0;
            own_q        <= '0;
            wr_q         <= 1'b0;
            last_q       <= IDX_W'(NUM_REQ - 1);
`ifdef REG_ARB_TIMEOUT_EN
            tmo_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            req_done <= '0;
`ifdef REG_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        state_q      <= ISSUE;
                        own_q        <= win_d;
                        grant        <= NUM_REQ'(1) << win_d;
                        wr_q         <= req_wr[win_d];
                        write_start  <= req_wr[win_d];
                        read_start   <= ~req_wr[win_d];
                        reg_out_addr <= addr_arr[win_d];
                        reg_out_data <= wdata_arr[win_d];
`ifdef REG_ARB_TIMEOUT_EN
                        tmo_q        <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (ack_m) begin
                        write_start <= 1'b0;
                        read_start  <= 1'b0;
                        if (done_m) begin
                            state_q   <= RESP;
                            req_done  <= grant;
                            req_rdata <= resp_data(wr_q, reg_in_data);
                        end else begin
                            state_q <= WAIT;
                        end
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        write_start <= 1'b0;
                        read_start  <= 1'b0;
                        state_q     <= RESP;
                        req_done    <= grant;
                        err_q       <= 1'b1;
                        req_rdata   <= 32'hDEAD_BEEF;
                    end
                    tmo_q <= tmo_q + 32'd1;
`endif
                end
                WAIT: begin
                    if (done_m) begin
                        state_q   <= RESP;
                        req_done  <= grant;
                        req_rdata <= resp_data(wr_q, reg_in_data);
                    end
`ifdef REG_ARB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q   <= RESP;
                        req_done  <= grant;
                        err_q     <= 1'b1;
                        req_rdata <= 32'hDEAD_BEEF;
                    end
                    tmo_q <= tmo_q + 32'd1;
`endif
                end
                RESP: begin
                    grant   <= '0;
                    last_q  <= own_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed self-checking bench for reg_access_arbiter (timeout steps need REG_ARB_TIMEOUT_EN).
module tb_reg_access_arbiter;

    localparam int N = 3;

    logic            aclk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_wr;
    logic [64*N-1:0] req_addr;
    logic [32*N-1:0] req_wdata;
    logic [N-1:0]    grant;
    logic [N-1:0]    req_done;
    logic            req_err;
    logic [31:0]     req_rdata;
    logic            write_start;
    logic            read_start;
    logic            write_start_ack;
    logic            read_start_ack;
    logic            sys_write_master_done;
    logic            sys_read_master_done;
    logic [63:0]     reg_out_addr;
    logic [31:0]     reg_out_data;
    logic [31:0]     reg_in_data;

    int n_cmp = 0;
    int n_mis = 0;

    reg_access_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(32'd100)) dut (
        .aclk(aclk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .write_start(write_start), .read_start(read_start),
        .write_start_ack(write_start_ack), .read_start_ack(read_start_ack),
        .sys_write_master_done(sys_write_master_done),
        .sys_read_master_done(sys_read_master_done),
        .reg_out_addr(reg_out_addr), .reg_out_data(reg_out_data),
        .reg_in_data(reg_in_data)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (!(write_start | read_start) && n < budget) begin
            tick();
            n++;
        end
        chk("start_seen", 64'(write_start | read_start), 64'd1);
    endtask

    initial begin
        int   g;
        logic wr_e;
        int   cnt;

        rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        write_start_ack = 1'b0; read_start_ack = 1'b0;
        sys_write_master_done = 1'b0; sys_read_master_done = 1'b0; reg_in_data = '0;
        repeat (2) tick();
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_done", 64'(req_done), 64'd0);
        chk("rst_err", 64'(req_err), 64'd0);
        chk("rst_rdata", 64'(req_rdata), 64'd0);
        chk("rst_ws", 64'(write_start), 64'd0);
        chk("rst_rs", 64'(read_start), 64'd0);
        chk("rst_addr", reg_out_addr, 64'd0);
        chk("rst_data", 64'(reg_out_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single write: ack in cycle 3, done in cycle 10
        req_wr = 3'b001; req_addr[63:0] = 64'h4_0000_0004; req_wdata[31:0] = 32'h1234_5678;
        req = 3'b001;
        tick();
        chk("wr_ws_c1", 64'(write_start), 64'd1);
        chk("wr_rs_c1", 64'(read_start), 64'd0);
        chk("wr_grant", 64'(grant), 64'b001);
        chk("wr_addr", reg_out_addr, 64'h4_0000_0004);
        chk("wr_data", 64'(reg_out_data), 64'h1234_5678);
        tick();
        chk("wr_ws_c2", 64'(write_start), 64'd1);
        tick();
        chk("wr_ws_c3", 64'(write_start), 64'd1);
        write_start_ack = 1'b1;
        tick();
        write_start_ack = 1'b0;
        chk("wr_ws_c4", 64'(write_start), 64'd0);
        reg_in_data = 32'hFFFF_FFFF;
        for (int c = 4; c < 10; c++) begin
            chk("wr_nodone_wait", 64'(req_done), 64'd0);
            tick();
        end
        sys_write_master_done = 1'b1;
        tick();
        sys_write_master_done = 1'b0;
        chk("wr_done", 64'(req_done), 64'b001);
        chk("wr_err", 64'(req_err), 64'd0);
        chk("wr_rdata", 64'(req_rdata), 64'd0);
        chk("wr_grant_resp", 64'(grant), 64'b001);
        chk("wr_addr_resp", reg_out_addr, 64'h4_0000_0004);
        req = 3'b000;
        tick();
        chk("wr_done_once", 64'(req_done), 64'd0);
        chk("wr_grant_clr", 64'(grant), 64'd0);

        // Single read from requester 2, with a stray write-done in WAIT
        req_wr = 3'b000; req_addr[191:128] = 64'ha000_001c; req = 3'b100;
        tick();
        chk("rd_rs", 64'(read_start), 64'd1);
        chk("rd_ws", 64'(write_start), 64'd0);
        chk("rd_grant", 64'(grant), 64'b100);
        chk("rd_addr", reg_out_addr, 64'ha000_001c);
        read_start_ack = 1'b1;
        tick();
        read_start_ack = 1'b0;
        chk("rd_rs_off", 64'(read_start), 64'd0);
        sys_write_master_done = 1'b1; reg_in_data = 32'h0BAD_0BAD;
        tick();
        sys_write_master_done = 1'b0;
        chk("rd_ignore_wdone", 64'(req_done), 64'd0);
        sys_read_master_done = 1'b1; reg_in_data = 32'h0001_0000;
        tick();
        sys_read_master_done = 1'b0;
        chk("rd_done", 64'(req_done), 64'b100);
        chk("rd_rdata", 64'(req_rdata), 64'h0001_0000);
        chk("rd_err", 64'(req_err), 64'd0);
        req = 3'b000;
        tick();
        chk("rd_done_once", 64'(req_done), 64'd0);
        chk("rd_grant_clr", 64'(grant), 64'd0);

        // Contention: all three held high, expect 0,1,2,0,1,2
        req_wr = 3'b101;
        for (int i = 0; i < N; i++) begin
            req_addr[64*i +: 64] = 64'h1000 + 64'(i * 16);
            req_wdata[32*i +: 32] = 32'hCAFE_0000 + 32'(i);
        end
        req = 3'b111;
        for (int t = 0; t < 6; t++) begin
            g = t % N;
            wr_e = req_wr[g];
            wait_start(8);
            chk("rr_grant", 64'(grant), 64'(1 << g));
            chk("rr_ws", 64'(write_start), 64'(wr_e));
            chk("rr_rs", 64'(read_start), 64'(!wr_e));
            chk("rr_addr", reg_out_addr, 64'h1000 + 64'(g * 16));
            if (wr_e) write_start_ack = 1'b1; else read_start_ack = 1'b1;
            tick();
            write_start_ack = 1'b0; read_start_ack = 1'b0;
            chk("rr_start_off", 64'(write_start | read_start), 64'd0);
            reg_in_data = 32'hC0DE_0000 + 32'(t);
            if (wr_e) sys_write_master_done = 1'b1; else sys_read_master_done = 1'b1;
            tick();
            sys_write_master_done = 1'b0; sys_read_master_done = 1'b0;
            chk("rr_done", 64'(req_done), 64'(1 << g));
            chk("rr_rdata", 64'(req_rdata), wr_e ? 64'd0 : 64'(32'hC0DE_0000 + 32'(t)));
            if (t == 5) req = 3'b000;
            tick();
            chk("rr_idle_gap", 64'(grant), 64'd0);
        end

        // Ack and done together in the second ISSUE cycle
        req_wr = 3'b010; req = 3'b010;
        tick();
        chk("ad_ws_c1", 64'(write_start), 64'd1);
        chk("ad_grant", 64'(grant), 64'b010);
        tick();
        chk("ad_ws_c2", 64'(write_start), 64'd1);
        write_start_ack = 1'b1; sys_write_master_done = 1'b1;
        tick();
        write_start_ack = 1'b0; sys_write_master_done = 1'b0;
        chk("ad_done", 64'(req_done), 64'b010);
        chk("ad_ws_off", 64'(write_start), 64'd0);
        req = 3'b000;
        tick();
        chk("ad_done_once", 64'(req_done), 64'd0);
        chk("ad_grant_clr", 64'(grant), 64'd0);

        // Reset during WAIT, then a stray done, then normal service of requester 0
        req_wr = 3'b000; req = 3'b001;
        tick();
        chk("rw_rs", 64'(read_start), 64'd1);
        read_start_ack = 1'b1;
        tick();
        read_start_ack = 1'b0;
        chk("rw_in_wait", 64'(read_start), 64'd0);
        rst_n = 1'b0; req = 3'b000;
        tick();
        rst_n = 1'b1;
        chk("rw_grant", 64'(grant), 64'd0);
        chk("rw_done", 64'(req_done), 64'd0);
        chk("rw_addr", reg_out_addr, 64'd0);
        chk("rw_data", 64'(reg_out_data), 64'd0);
        chk("rw_rdata", 64'(req_rdata), 64'd0);
        chk("rw_starts", 64'({write_start, read_start}), 64'd0);
        sys_read_master_done = 1'b1;
        tick();
        sys_read_master_done = 1'b0;
        chk("rw_stray_done", 64'(req_done), 64'd0);
        chk("rw_stray_grant", 64'(grant), 64'd0);
        req_wr = 3'b001; req_addr[63:0] = 64'h4_0000_0040; req_wdata[31:0] = 32'hA5A5_5A5A;
        req = 3'b001;
        tick();
        chk("rw2_grant", 64'(grant), 64'b001);
        chk("rw2_ws", 64'(write_start), 64'd1);
        chk("rw2_addr", reg_out_addr, 64'h4_0000_0040);
        chk("rw2_data", 64'(reg_out_data), 64'hA5A5_5A5A);
        write_start_ack = 1'b1;
        tick();
        write_start_ack = 1'b0;
        sys_write_master_done = 1'b1;
        tick();
        sys_write_master_done = 1'b0;
        chk("rw2_done", 64'(req_done), 64'b001);
        req = 3'b000;
        tick();

`ifdef REG_ARB_TIMEOUT_EN
        // Watchdog: requester 1 read never completes, limit 100
        req_wr = 3'b000; req = 3'b011;
        tick();
        chk("to_grant", 64'(grant), 64'b010);
        read_start_ack = 1'b1;
        tick();
        read_start_ack = 1'b0;
        cnt = 2;
        while (req_done == '0 && cnt < 200) begin
            tick();
            cnt++;
        end
        chk("to_cycles", 64'(cnt), 64'd101);
        chk("to_done", 64'(req_done), 64'b010);
        chk("to_err", 64'(req_err), 64'd1);
        chk("to_rdata", 64'(req_rdata), 64'hDEAD_BEEF);
        req = 3'b001;
        tick();
        wait_start(4);
        chk("to_next_grant", 64'(grant), 64'b001);
        read_start_ack = 1'b1; sys_read_master_done = 1'b1; reg_in_data = 32'h0000_0007;
        tick();
        read_start_ack = 1'b0; sys_read_master_done = 1'b0;
        chk("to_next_done", 64'(req_done), 64'b001);
        chk("to_next_err", 64'(req_err), 64'd0);
        chk("to_next_rdata", 64'(req_rdata), 64'h7);
        req = 3'b000;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
